butterfly_pipe: RTL and testbench

//  Pipelined, parametrised modular NTT butterfly for the transform datapath (default q = 8380417).

---
 rtl/ntt_pkg.sv | 49 ++++
 rtl/mod_mult_barrett.sv | 50 +++++
 rtl/butterfly_pipe.sv | 186 ++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared NTT constants, butterfly mode encoding and modular helper arithmetic.
package ntt_pkg;

  localparam int unsigned Q     = 8380417;
  localparam int unsigned WIDTH = 23;
  localparam int unsigned K     = $clog2(Q);
  localparam longint unsigned BARRETT_MU = (64'd1 << (2 * K)) / 64'(Q);

  typedef logic [WIDTH-1:0] coeff_t;
  typedef logic [31:0]      word_t;

  typedef enum logic [1:0] {
    MODE_CT      = 2'b00,
    MODE_GS      = 2'b01,
    MODE_GS_HALF = 2'b10
  } mode_e;

  // Reserved encoding 11 falls back to Cooley-Tukey.
  function automatic mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_GS;
      2'b10:   return MODE_GS_HALF;
      default: return MODE_CT;
    endcase
  endfunction

  // Operands are in [0,q); one conditional correction brings the result back.
  function automatic word_t mod_add(input word_t x, input word_t y, input word_t q);
    logic [32:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[31:0];
  endfunction

  function automatic word_t mod_sub(input word_t x, input word_t y, input word_t q);
    logic [32:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + {1'b0, q};
    return d[31:0];
  endfunction

  // Multiply by 2^-1 mod q: odd values borrow one q to become even.
  function automatic word_t mod_halve(input word_t x, input word_t q);
    logic [32:0] h;
    h = x[0] ? ({1'b0, x} + {1'b0, q}) : {1'b0, x};
    return h[32:1];
  endfunction

endpackage

// File: rtl/mod_mult_barrett.sv
// Two-stage modular multiplier: full product register, then Barrett-reduced register.
module mod_mult_barrett #(
  parameter int unsigned Q     = ntt_pkg::Q,
  parameter int unsigned WIDTH = ntt_pkg::WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] m_i,
  input  logic [WIDTH-1:0] w_i,
  output logic [WIDTH-1:0] r_o
);

  localparam int unsigned K  = $clog2(Q);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned EW = 2 * WIDTH + 4;
  localparam longint unsigned MU = (64'd1 << (2 * K)) / 64'(Q);

  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [EW-1:0]    x1, qhat, rem;

  // Quotient estimate undershoots by at most two, hence two corrections.
  always_comb begin
    prod_d = prod_q;
    r_d    = r_q;
    x1     = EW'(prod_q >> (K - 1));
    qhat   = (x1 * EW'(MU)) >> (K + 1);
    rem    = EW'(prod_q) - qhat * EW'(Q);
    if (rem >= EW'(Q)) rem = rem - EW'(Q);
    if (rem >= EW'(Q)) rem = rem - EW'(Q);
    if (en_i) begin
      prod_d = PW'(m_i) * PW'(w_i);
      r_d    = WIDTH'(rem);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prod_q <= '0;
      r_q    <= '0;
    end else begin
      prod_q <= prod_d;
      r_q    <= r_d;
    end
  end

  assign r_o = r_q;

endmodule

// File: rtl/butterfly_pipe.sv
// Four-stage multi-lane NTT butterfly (CT / GS / GS with halving) on a globally stalled stream.
module butterfly_pipe #(
  parameter int unsigned Q     = ntt_pkg::Q,
  parameter int unsigned WIDTH = ntt_pkg::WIDTH,
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [LANES*(WIDTH+1)-1:0] a_i,
  input  logic [LANES*(WIDTH+1)-1:0] b_i,
  input  logic [LANES*WIDTH-1:0]     twiddle_i,
  input  logic [1:0]                 mode_i,
  input  logic [TAG_W-1:0]           tag_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LANES*WIDTH-1:0]     a_out_o,
  output logic [LANES*WIDTH-1:0]     b_out_o,
  output logic [TAG_W-1:0]           tag_o
);

  import ntt_pkg::*;

  localparam int unsigned AW = WIDTH + 1;

  typedef logic [LANES-1:0][WIDTH-1:0] lane_vec_t;

  logic advance;

  logic       s0_valid_q, s0_valid_d, s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  mode_e      s0_mode_q, s0_mode_d, s1_mode_q, s1_mode_d, s2_mode_q, s2_mode_d;
  logic [TAG_W-1:0] s0_tag_q, s0_tag_d, s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d;
  lane_vec_t  s0_keep_q, s0_keep_d, s1_keep_q, s1_keep_d, s2_keep_q, s2_keep_d;
  lane_vec_t  s0_m_q, s0_m_d, s0_w_q, s0_w_d;
  logic       out_valid_q, out_valid_d;
  lane_vec_t  a_out_q, a_out_d, b_out_q, b_out_d;
  logic [TAG_W-1:0] tag_out_q, tag_out_d;
  lane_vec_t  t_w;

  logic [AW-1:0]    araw, braw;
  logic [WIDTH-1:0] ar, br, sum, dif, keep, t;

  // keep carries a' (CT) or s (GS) alongside the multiplier; m is its multiplicand.
  always_comb begin
    advance     = !out_valid_q || out_ready_i;
    s0_valid_d  = s0_valid_q;
    s0_mode_d   = s0_mode_q;
    s0_tag_d    = s0_tag_q;
    s0_keep_d   = s0_keep_q;
    s0_m_d      = s0_m_q;
    s0_w_d      = s0_w_q;
    s1_valid_d  = s1_valid_q;
    s1_mode_d   = s1_mode_q;
    s1_tag_d    = s1_tag_q;
    s1_keep_d   = s1_keep_q;
    s2_valid_d  = s2_valid_q;
    s2_mode_d   = s2_mode_q;
    s2_tag_d    = s2_tag_q;
    s2_keep_d   = s2_keep_q;
    out_valid_d = out_valid_q;
    a_out_d     = a_out_q;
    b_out_d     = b_out_q;
    tag_out_d   = tag_out_q;
    araw        = '0;
    braw        = '0;
    ar          = '0;
    br          = '0;
    sum         = '0;
    dif         = '0;
    keep        = '0;
    t           = '0;

    if (advance) begin
      s0_valid_d = in_valid_i;
      s0_mode_d  = decode_mode(mode_i);
      s0_tag_d   = tag_i;
      for (int l = 0; l < LANES; l++) begin
        araw = a_i[l*AW +: AW];
        braw = b_i[l*AW +: AW];
        ar   = (araw >= AW'(Q)) ? WIDTH'(araw - AW'(Q)) : WIDTH'(araw);
        br   = (braw >= AW'(Q)) ? WIDTH'(braw - AW'(Q)) : WIDTH'(braw);
        sum  = WIDTH'(mod_add(32'(ar), 32'(br), 32'(Q)));
        dif  = WIDTH'(mod_sub(32'(ar), 32'(br), 32'(Q)));
        s0_keep_d[l] = (s0_mode_d == MODE_CT) ? ar : sum;
        s0_m_d[l]    = (s0_mode_d == MODE_CT) ? br : dif;
        s0_w_d[l]    = twiddle_i[l*WIDTH +: WIDTH];
      end

      s1_valid_d = s0_valid_q;
      s1_mode_d  = s0_mode_q;
      s1_tag_d   = s0_tag_q;
      s1_keep_d  = s0_keep_q;

      s2_valid_d = s1_valid_q;
      s2_mode_d  = s1_mode_q;
      s2_tag_d   = s1_tag_q;
      s2_keep_d  = s1_keep_q;

      out_valid_d = s2_valid_q;
      tag_out_d   = s2_tag_q;
      for (int l = 0; l < LANES; l++) begin
        keep = s2_keep_q[l];
        t    = t_w[l];
        case (s2_mode_q)
          MODE_GS: begin
            a_out_d[l] = keep;
            b_out_d[l] = t;
          end
          MODE_GS_HALF: begin
            a_out_d[l] = WIDTH'(mod_halve(32'(keep), 32'(Q)));
            b_out_d[l] = WIDTH'(mod_halve(32'(t), 32'(Q)));
          end
          default: begin
            a_out_d[l] = WIDTH'(mod_add(32'(keep), 32'(t), 32'(Q)));
            b_out_d[l] = WIDTH'(mod_sub(32'(keep), 32'(t), 32'(Q)));
          end
        endcase
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mod_mult_barrett #(
      .Q     (Q),
      .WIDTH (WIDTH)
    ) u_mult (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (advance),
      .m_i    (s0_m_q[g]),
      .w_i    (s0_w_q[g]),
      .r_o    (t_w[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s0_valid_q  <= 1'b0;
      s0_mode_q   <= MODE_CT;
      s0_tag_q    <= '0;
      s0_keep_q   <= '0;
      s0_m_q      <= '0;
      s0_w_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_CT;
      s1_tag_q    <= '0;
      s1_keep_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_mode_q   <= MODE_CT;
      s2_tag_q    <= '0;
      s2_keep_q   <= '0;
      out_valid_q <= 1'b0;
      a_out_q     <= '0;
      b_out_q     <= '0;
      tag_out_q   <= '0;
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_mode_q   <= s0_mode_d;
      s0_tag_q    <= s0_tag_d;
      s0_keep_q   <= s0_keep_d;
      s0_m_q      <= s0_m_d;
      s0_w_q      <= s0_w_d;
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_tag_q    <= s1_tag_d;
      s1_keep_q   <= s1_keep_d;
      s2_valid_q  <= s2_valid_d;
      s2_mode_q   <= s2_mode_d;
      s2_tag_q    <= s2_tag_d;
      s2_keep_q   <= s2_keep_d;
      out_valid_q <= out_valid_d;
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      tag_out_q   <= tag_out_d;
    end
  end

  assign in_ready_o  = advance;
  assign out_valid_o = out_valid_q;
  assign a_out_o     = a_out_q;
  assign b_out_o     = b_out_q;
  assign tag_o       = tag_out_q;

endmodule

// File: tb/tb_butterfly_pipe.sv
// Scoreboard bench for butterfly_pipe (2 lanes): directed vectors, random stream with stall, mid-stream reset.
module tb_butterfly_pipe;

  localparam int unsigned QQ = 8380417;
  localparam int unsigned W  = 23;
  localparam int unsigned AW = W + 1;
  localparam int unsigned L  = 2;
  localparam int unsigned TW = 8;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [L*AW-1:0]   a_i, b_i;
  logic [L*W-1:0]    twiddle_i;
  logic [1:0]        mode_i;
  logic [TW-1:0]     tag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [L*W-1:0]    a_out_o, b_out_o;
  logic [TW-1:0]     tag_o;

  typedef struct packed {
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [TW-1:0]  tag;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;

  always #5 clk = ~clk;

  butterfly_pipe #(
    .LANES (L),
    .TAG_W (TW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .twiddle_i   (twiddle_i),
    .mode_i      (mode_i),
    .tag_i       (tag_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .a_out_o     (a_out_o),
    .b_out_o     (b_out_o),
    .tag_o       (tag_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Mathematical reference: plain integer mod arithmetic per lane.
  function automatic longint unsigned halve_ref(input longint unsigned x);
    return (x % 2 == 0) ? x / 2 : (x + QQ) / 2;
  endfunction

  function automatic void model(input logic [L*AW-1:0] a, input logic [L*AW-1:0] b,
                                input logic [L*W-1:0] w, input logic [1:0] mode,
                                output logic [L*W-1:0] ea, output logic [L*W-1:0] eb);
    longint unsigned av, bv, tw, s, d, t, ra, rb;
    ea = '0;
    eb = '0;
    for (int l = 0; l < L; l++) begin
      av = 64'(a[l*AW +: AW]) % QQ;
      bv = 64'(b[l*AW +: AW]) % QQ;
      tw = 64'(w[l*W +: W]);
      if (mode == 2'b01 || mode == 2'b10) begin
        s  = (av + bv) % QQ;
        d  = (av + QQ - bv) % QQ;
        t  = (d * tw) % QQ;
        ra = (mode == 2'b10) ? halve_ref(s) : s;
        rb = (mode == 2'b10) ? halve_ref(t) : t;
      end else begin
        t  = (bv * tw) % QQ;
        ra = (av + t) % QQ;
        rb = (av + QQ - t) % QQ;
      end
      ea[l*W +: W] = W'(ra);
      eb[l*W +: W] = W'(rb);
    end
  endfunction

  function automatic logic [L*AW-1:0] dup_a(input int unsigned x);
    return {AW'(x), AW'(x)};
  endfunction

  function automatic logic [L*W-1:0] dup_w(input int unsigned x);
    return {W'(x), W'(x)};
  endfunction

  task automatic set_ready();
    out_ready_i = (stall_cnt == 0);
    if (stall_cnt > 0) stall_cnt--;
  endtask

  // Called at posedge+1; holds the beat until accepted, pushes expectation on acceptance.
  task automatic send(input logic [L*AW-1:0] a, input logic [L*AW-1:0] b,
                      input logic [L*W-1:0] w, input logic [1:0] mode, input logic [TW-1:0] tag,
                      input logic [L*W-1:0] ea, input logic [L*W-1:0] eb);
    bit acc = 1'b0;
    a_i = a; b_i = b; twiddle_i = w; mode_i = mode; tag_i = tag;
    in_valid_i = 1'b1;
    for (int c = 0; c < 64 && !acc; c++) begin
      set_ready();
      @(negedge clk);
      if (in_ready_o) begin
        sb_q.push_back('{a: ea, b: eb, tag: tag});
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 64 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid_i = 1'b0;
    for (int c = 0; c < n; c++) begin
      set_ready();
      @(posedge clk); #1;
    end
  endtask

  task automatic send_rand();
    logic [L*AW-1:0] a, b;
    logic [L*W-1:0]  w, ea, eb;
    logic [1:0]      mode;
    logic [TW-1:0]   tag;
    for (int l = 0; l < L; l++) begin
      a[l*AW +: AW] = AW'($urandom_range(0, 2 * QQ - 1));
      b[l*AW +: AW] = AW'($urandom_range(0, 2 * QQ - 1));
      w[l*W +: W]   = W'($urandom_range(0, QQ - 1));
    end
    mode = 2'($urandom_range(0, 3));
    tag  = TW'($urandom);
    model(a, b, w, mode, ea, eb);
    send(a, b, w, mode, tag, ea, eb);
  endtask

  // Monitor: pops on every transfer, checks hold-while-stalled.
  initial begin
    bit             held = 1'b0;
    logic [L*W-1:0] pa, pb;
    logic [TW-1:0]  pt;
    exp_t           e;
    pa = '0; pb = '0; pt = '0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", 64'(out_valid_o), 64'd1);
          chk("hold_a", 64'(a_out_o), 64'(pa));
          chk("hold_b", 64'(b_out_o), 64'(pb));
          chk("hold_tag", 64'(tag_o), 64'(pt));
        end
        if (out_valid_o && !out_ready_i) begin
          chk("stall_in_ready", 64'(in_ready_o), 64'd0);
          held = 1'b1;
          pa = a_out_o; pb = b_out_o; pt = tag_o;
        end else begin
          held = 1'b0;
        end
        if (out_valid_o && out_ready_i) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat tag %0d expected no output", tag_o);
          end else begin
            e = sb_q.pop_front();
            chk("out_a", 64'(a_out_o), 64'(e.a));
            chk("out_b", 64'(b_out_o), 64'(e.b));
            chk("out_tag", 64'(tag_o), 64'(e.tag));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_ni = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = '0; b_i = '0; twiddle_i = '0; mode_i = '0; tag_i = '0;
    #23;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_a_out", 64'(a_out_o), 64'd0);
    chk("rst_b_out", 64'(b_out_o), 64'd0);
    chk("rst_tag", 64'(tag_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_ni = 1'b1;
    @(posedge clk); #1;
    idle(2);

    // Latency: count edges starting with the accepting one.
    send(dup_a(1), dup_a(1), dup_w(1), 2'b00, 8'h01, dup_w(2), dup_w(0));
    lat = 1;
    while (!out_valid_o && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd4);
    idle(2);

    send(dup_a(0), dup_a(1), dup_w(1), 2'b00, 8'h02, dup_w(1), dup_w(QQ - 1));
    send(dup_a(0), dup_a(QQ - 1), dup_w(QQ - 1), 2'b00, 8'h03, dup_w(1), dup_w(QQ - 1));
    send(dup_a(QQ + 3), dup_a(0), dup_w(0), 2'b00, 8'h04, dup_w(3), dup_w(3));
    send(dup_a(5), dup_a(3), dup_w(2), 2'b01, 8'h05, dup_w(8), dup_w(4));
    send(dup_a(1), dup_a(0), dup_w(1), 2'b10, 8'h06, dup_w(4190209), dup_w(4190209));
    send(dup_a(1), dup_a(1), dup_w(1), 2'b11, 8'h07, dup_w(2), dup_w(0));
    idle(8);

    for (int i = 0; i < 10; i++) begin
      if (i == 5) stall_cnt = 3;
      send_rand();
    end
    idle(10);

    // Park three beats behind a stalled output, then reset.
    stall_cnt = 20;
    for (int i = 0; i < 3; i++) send_rand();
    idle(3);
    chk("pre_reset_valid", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_a_out", 64'(a_out_o), 64'd0);
    chk("mid_rst_tag", 64'(tag_o), 64'd0);
    sb_q.delete();
    stall_cnt = 0;
    idle(2);
    rst_ni = 1'b1;
    idle(12);

    for (int i = 0; i < 3; i++) send_rand();
    for (int c = 0; c < 100 && sb_q.size() != 0; c++) idle(1);
    idle(2);
    chk("drain_empty", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
